// File: rtl/if_id_skid_stage_pkg.sv
// rtl/if_id_skid_stage_pkg.sv - shared widths and NOP encoding for the IF->ID boundary stage
package if_id_skid_stage_pkg;

  localparam int PC_W_DEF   = 64;
  localparam int INST_W_DEF = 32;

  // addi x0,x0,0
  localparam logic [31:0] NOP_INST = 32'h00000013;

  function automatic logic [1:0] count_valid(input logic a, input logic b);
    return {1'b0, a} + {1'b0, b};
  endfunction

endpackage

// File: rtl/if_id_slot.sv
// rtl/if_id_slot.sv - one {pc, inst} holding slot with valid bit, load enable and clear
module if_id_slot
  import if_id_skid_stage_pkg::*;
#(
  parameter int PC_W   = PC_W_DEF,
  parameter int INST_W = INST_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear,
  input  logic [PC_W-1:0]   d_pc,
  input  logic [INST_W-1:0] d_inst,
  output logic              valid,
  output logic [PC_W-1:0]   pc,
  output logic [INST_W-1:0] inst
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= 1'b0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
    end
  end

  // Data only moves on a real load; stale contents are masked by valid downstream.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc   <= '0;
      inst <= '0;
    end else if (load && !clear) begin
      pc   <= d_pc;
      inst <= d_inst;
    end
  end

endmodule

// File: rtl/if_id_skid_stage.sv
// rtl/if_id_skid_stage.sv - IF->ID pipeline boundary with main + skid slot and registered in_ready
module if_id_skid_stage
  import if_id_skid_stage_pkg::*;
#(
  parameter int                PC_W   = PC_W_DEF,
  parameter int                INST_W = INST_W_DEF,
  parameter logic [INST_W-1:0] NOP    = INST_W'(NOP_INST)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [INST_W-1:0] in_inst,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [INST_W-1:0] out_inst,
  output logic [1:0]        occupancy
);

  logic              main_v, skid_v;
  logic [PC_W-1:0]   main_pc, skid_pc;
  logic [INST_W-1:0] main_inst, skid_inst;

  logic              main_load, main_clear, skid_load, skid_clear;
  logic [PC_W-1:0]   main_d_pc;
  logic [INST_W-1:0] main_d_inst;
  logic              skid_v_next;
  logic              in_ready_q;
  logic              accept, deliver;

  assign accept  = in_valid & in_ready_q;
  assign deliver = main_v & out_ready;

  always_comb begin
    main_load  = 1'b0;
    main_clear = 1'b0;
    skid_load  = 1'b0;
    skid_clear = 1'b0;
    if (flush) begin
      main_clear = 1'b1;
      skid_clear = 1'b1;
    end else if (skid_v) begin
      // Full: ready is low, so only a deliver can move state (skid drains into main).
      if (deliver) begin
        main_load  = 1'b1;
        skid_clear = 1'b1;
      end
    end else if (main_v) begin
      if (accept && deliver) begin
        main_load = 1'b1;
      end else if (accept) begin
        skid_load = 1'b1;
      end else if (deliver) begin
        main_clear = 1'b1;
      end
    end else if (accept) begin
      main_load = 1'b1;
    end
  end

  assign main_d_pc   = skid_v ? skid_pc   : in_pc;
  assign main_d_inst = skid_v ? skid_inst : in_inst;

  if_id_slot #(.PC_W(PC_W), .INST_W(INST_W)) u_main (
    .clk    (clk),
    .rst    (rst),
    .load   (main_load),
    .clear  (main_clear),
    .d_pc   (main_d_pc),
    .d_inst (main_d_inst),
    .valid  (main_v),
    .pc     (main_pc),
    .inst   (main_inst)
  );

  if_id_slot #(.PC_W(PC_W), .INST_W(INST_W)) u_skid (
    .clk    (clk),
    .rst    (rst),
    .load   (skid_load),
    .clear  (skid_clear),
    .d_pc   (in_pc),
    .d_inst (in_inst),
    .valid  (skid_v),
    .pc     (skid_pc),
    .inst   (skid_inst)
  );

  // in_ready tracks the skid slot's next state so fetch never sees a combinational path from decode.
  assign skid_v_next = skid_load | (skid_v & ~skid_clear);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_ready_q <= 1'b1;
    end else begin
      in_ready_q <= ~skid_v_next;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = main_v;
  assign out_pc    = main_v ? main_pc   : '0;
  assign out_inst  = main_v ? main_inst : NOP;
  assign occupancy = count_valid(main_v, skid_v);

endmodule

// File: tb/tb_if_id_skid_stage.sv
// tb/tb_if_id_skid_stage.sv - self-checking bench for if_id_skid_stage
module tb_if_id_skid_stage;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_pc;
  logic [31:0] in_inst;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic [31:0] out_inst;
  logic [1:0]  occupancy;

  int checks   = 0;
  int failures = 0;

  if_id_skid_stage dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_inst   (in_inst),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_inst  (out_inst),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: an ordered queue of at most two held entries.
  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
  } ent_t;

  ent_t mq[$];
  bit   m_ready = 1'b1;
  bit   m_acc, m_del;
  ent_t m_ent;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq.delete();
      m_ready = 1'b1;
    end else begin
      m_acc = in_valid && m_ready;
      m_del = (mq.size() > 0) && out_ready;
      if (flush) begin
        mq.delete();
      end else begin
        if (m_del) m_ent = mq.pop_front();
        if (m_acc) mq.push_back('{pc: in_pc, inst: in_inst});
      end
      m_ready = (mq.size() < 2);
    end
  end

  always @(negedge clk) begin
    chk("out_valid", {63'd0, out_valid}, {63'd0, mq.size() > 0});
    chk("out_pc",    out_pc, (mq.size() > 0) ? mq[0].pc : 64'd0);
    chk("out_inst",  {32'd0, out_inst}, {32'd0, (mq.size() > 0) ? mq[0].inst : NOP});
    chk("occupancy", {62'd0, occupancy}, 64'(mq.size()));
    chk("in_ready",  {63'd0, in_ready}, {63'd0, m_ready});
  end

  // Delivery log from the DUT, used against hand-written expected sequences.
  logic [63:0] log_pc[$];
  logic [31:0] log_inst[$];

  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      log_pc.push_back(out_pc);
      log_inst.push_back(out_inst);
    end
  end

  task automatic drive(input bit v, input logic [63:0] pc, input logic [31:0] inst,
                       input bit ordy, input bit fl);
    in_valid  = v;
    in_pc     = pc;
    in_inst   = inst;
    out_ready = ordy;
    flush     = fl;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    log_pc.delete();
    log_inst.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0;
    drive(0, 64'd0, 32'd0, 0, 0);
    repeat (2) step();
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_pc",    out_pc, 64'd0);
    chk("rst_out_inst",  {32'd0, out_inst}, 64'h13);
    chk("rst_in_ready",  {63'd0, in_ready}, 64'd1);
    chk("rst_occ",       {62'd0, occupancy}, 64'd0);
    rst = 1'b1;
    step();

    // Streaming with no stall.
    for (int k = 0; k < 8; k++) begin
      drive(1, 64'h80000000 + 64'(4 * k), 32'h00100093 + 32'(k), 1, 0);
      step();
      chk("stream_pc",    out_pc, 64'h80000000 + 64'(4 * k));
      chk("stream_occ",   {62'd0, occupancy}, 64'd1);
      chk("stream_ready", {63'd0, in_ready}, 64'd1);
    end
    drive(0, 64'd0, 32'd0, 1, 0);
    step();
    chk("stream_drain_occ", {62'd0, occupancy}, 64'd0);

    // Backpressure fills both slots and holds off the third beat.
    clear_log();
    drive(1, 64'h100, 32'h0000_0100, 0, 0);
    step();
    chk("bp_ready1", {63'd0, in_ready}, 64'd1);
    drive(1, 64'h104, 32'h0000_0104, 0, 0);
    step();
    chk("bp_ready2", {63'd0, in_ready}, 64'd0);
    chk("bp_occ2",   {62'd0, occupancy}, 64'd2);
    drive(1, 64'h108, 32'h0000_0108, 0, 0);
    repeat (2) begin
      step();
      chk("bp_hold_ready", {63'd0, in_ready}, 64'd0);
      chk("bp_hold_pc",    out_pc, 64'h100);
    end
    drive(1, 64'h108, 32'h0000_0108, 1, 0);
    step();
    chk("bp_drain_pc", out_pc, 64'h104);
    step();
    chk("bp_accept_pc", out_pc, 64'h108);
    drive(0, 64'd0, 32'd0, 1, 0);
    step();
    chk("bp_log_len", 64'(log_pc.size()), 64'd3);
    if (log_pc.size() == 3) begin
      chk("bp_log0", log_pc[0], 64'h100);
      chk("bp_log1", log_pc[1], 64'h104);
      chk("bp_log2", log_pc[2], 64'h108);
    end

    // Flush while full, with an incoming beat and a deliver in the same cycle.
    drive(1, 64'h180, 32'h0000_0180, 0, 0);
    step();
    drive(1, 64'h184, 32'h0000_0184, 0, 0);
    step();
    chk("fl_occ_full", {62'd0, occupancy}, 64'd2);
    clear_log();
    drive(1, 64'h188, 32'h0000_0188, 1, 1);
    step();
    chk("fl_occ",       {62'd0, occupancy}, 64'd0);
    chk("fl_out_valid", {63'd0, out_valid}, 64'd0);
    chk("fl_in_ready",  {63'd0, in_ready}, 64'd1);
    chk("fl_out_inst",  {32'd0, out_inst}, 64'h13);
    chk("fl_log_len",   64'(log_pc.size()), 64'd1);
    if (log_pc.size() == 1) chk("fl_log0", log_pc[0], 64'h180);
    drive(1, 64'h200, 32'h0000_0200, 1, 0);
    step();
    chk("fl_post_pc",    out_pc, 64'h200);
    chk("fl_post_valid", {63'd0, out_valid}, 64'd1);
    drive(0, 64'd0, 32'd0, 1, 0);
    step();

    // Retracting fetch: only the valid beats are taken.
    clear_log();
    drive(1, 64'h300, 32'hAAAA_0013, 1, 0);
    step();
    drive(0, 64'h304, 32'hDEAD_BEEF, 1, 0);
    step();
    drive(1, 64'h308, 32'h1234_5678, 1, 0);
    step();
    drive(0, 64'h30c, 32'hFFFF_FFFF, 1, 0);
    repeat (2) step();
    chk("rt_log_len", 64'(log_pc.size()), 64'd2);
    if (log_pc.size() == 2) begin
      chk("rt_pc0",   log_pc[0], 64'h300);
      chk("rt_inst0", {32'd0, log_inst[0]}, 64'hAAAA_0013);
      chk("rt_pc1",   log_pc[1], 64'h308);
      chk("rt_inst1", {32'd0, log_inst[1]}, 64'h1234_5678);
    end

    // Asynchronous reset with both slots held.
    drive(1, 64'h400, 32'h0000_0400, 0, 0);
    step();
    drive(1, 64'h404, 32'h0000_0404, 0, 0);
    step();
    chk("ar_occ_before", {62'd0, occupancy}, 64'd2);
    #2;
    rst = 1'b0;
    #1;
    chk("ar_out_valid", {63'd0, out_valid}, 64'd0);
    chk("ar_out_inst",  {32'd0, out_inst}, 64'h13);
    chk("ar_in_ready",  {63'd0, in_ready}, 64'd1);
    chk("ar_occ",       {62'd0, occupancy}, 64'd0);
    drive(0, 64'd0, 32'd0, 0, 0);
    repeat (2) step();
    rst = 1'b1;
    step();

    // Random traffic checked every cycle against the model.
    begin
      logic [63:0] pc_ctr;
      pc_ctr = 64'h1000;
      for (int i = 0; i < 10000; i++) begin
        drive(1'($urandom_range(1)), pc_ctr, $urandom, 1'($urandom_range(1)),
              ($urandom_range(99) < 5));
        pc_ctr = pc_ctr + 64'd4;
        step();
      end
    end
    drive(0, 64'd0, 32'd0, 1, 0);
    repeat (3) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
